// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//
// Moore sequencer for a multi-cycle MIPS datapath with one unified
// instruction/data memory. Each instruction walks through 3-5 states; every
// datapath enable and mux select is decoded from the registered state (plus
// op/funct), with mem_ready qualifying the memory-phase strobes.
//
// Handshake: mem_ready is a completion flag from memory. In FETCH, MEMRD and
// MEMWR the access strobe is held and the FSM waits in place until a cycle in
// which mem_ready=1; that cycle completes the access and the FSM advances.
// In every other state mem_ready is ignored.
//
// Ports
//   clock        in   rising-edge clock
//   reset        in   synchronous, active-low reset
//   op[5:0]      in   opcode from the instruction register
//   funct[5:0]   in   R-type function field
//   mem_ready    in   memory access completes this cycle
//   pcwrite      out  unconditional PC load
//   pcwritecond  out  PC load qualified by ALU zero
//   invertzero   out  invert the zero qualifier (bne)
//   iord         out  memory address select: 0=PC, 1=ALUOut
//   memread      out  memory read strobe
//   memwrite     out  memory write strobe
//   irwrite      out  instruction register load
//   memtoreg     out  register write data: 1=memory data, 0=ALUOut
//   regdst       out  destination register: 1=rd, 0=rt
//   regwrite     out  register file write
//   alusrca      out  ALU A: 0=PC, 1=register A
//   alusrcb[1:0] out  ALU B: 00=B, 01=4, 10=ext imm, 11=sext imm<<2
//   zeroext      out  zero-extend immediate (ori)
//   pcsrc[1:0]   out  PC source: 00=ALU, 01=ALUOut, 10=jump target
//   alucontrol   out  ALU op: 010 add, 110 sub, 000 and, 001 or, 111 slt
//   state[3:0]   out  current FSM state (debug)
//   illegal      out  unsupported op/funct detected this cycle
//   instr_done   out  final cycle of the current instruction
// ---------------------------------------------------------------------------
module multicycle_control (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       pcwrite,
    output logic       pcwritecond,
    output logic       invertzero,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic       memtoreg,
    output logic       regdst,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       zeroext,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic [3:0] state,
    output logic       illegal,
    output logic       instr_done
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTEXEC  = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_IMMEXEC = 4'd9,
        S_IMMWB   = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    state_t     r_state;
    state_t     w_next;
    logic       w_op_mem;
    logic       w_op_branch;
    logic       w_op_imm;
    logic       w_funct_ok;
    logic [2:0] w_rt_alu;

    // Opcode classes used by the DECODE dispatch
    assign w_op_mem    = (op == OP_LW)  || (op == OP_SW);
    assign w_op_branch = (op == OP_BEQ) || (op == OP_BNE);
    assign w_op_imm    = (op == OP_ADDI) || (op == OP_ORI);

    // R-type funct decode; w_funct_ok=0 marks an unsupported funct
    always_comb begin
        w_funct_ok = 1'b1;
        w_rt_alu   = 3'b010;
        case (funct)
            6'b100000: w_rt_alu = 3'b010;
            6'b100010: w_rt_alu = 3'b110;
            6'b100100: w_rt_alu = 3'b000;
            6'b100101: w_rt_alu = 3'b001;
            6'b101010: w_rt_alu = 3'b111;
            default:   w_funct_ok = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:   w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (w_op_mem)               w_next = S_MEMADR;
                else if (op == OP_RTYPE)    w_next = S_RTEXEC;
                else if (w_op_branch)       w_next = S_BRANCH;
                else if (w_op_imm)          w_next = S_IMMEXEC;
                else if (op == OP_J)        w_next = S_JUMP;
                else                        w_next = S_FETCH;
            end
            S_MEMADR:  w_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   w_next = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:   w_next = S_FETCH;
            S_MEMWR:   w_next = mem_ready ? S_FETCH : S_MEMWR;
            S_RTEXEC:  w_next = w_funct_ok ? S_ALUWB : S_FETCH;
            S_ALUWB:   w_next = S_FETCH;
            S_BRANCH:  w_next = S_FETCH;
            S_IMMEXEC: w_next = S_IMMWB;
            S_IMMWB:   w_next = S_FETCH;
            S_JUMP:    w_next = S_FETCH;
            default:   w_next = S_FETCH;
        endcase
    end

    // Output decode. While reset is low every strobe stays 0 and the
    // mux selects sit on the FETCH pattern so the datapath is quiescent.
    always_comb begin
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        invertzero  = 1'b0;
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        irwrite     = 1'b0;
        memtoreg    = 1'b0;
        regdst      = 1'b0;
        regwrite    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        zeroext     = 1'b0;
        pcsrc       = 2'b00;
        alucontrol  = 3'b010;
        illegal     = 1'b0;
        instr_done  = 1'b0;
        if (!reset) begin
            alusrcb = 2'b01;
        end else begin
            case (r_state)
                S_FETCH: begin
                    memread = 1'b1;
                    alusrcb = 2'b01;
                    irwrite = mem_ready;
                    pcwrite = mem_ready;
                end
                S_DECODE: begin
                    // Branch target precomputed into ALUOut
                    alusrcb = 2'b11;
                    if (!(w_op_mem || w_op_branch || w_op_imm ||
                          op == OP_RTYPE || op == OP_J)) begin
                        illegal    = 1'b1;
                        instr_done = 1'b1;
                    end
                end
                S_MEMADR: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                S_MEMRD: begin
                    iord    = 1'b1;
                    memread = 1'b1;
                end
                S_MEMWB: begin
                    memtoreg   = 1'b1;
                    regwrite   = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEMWR: begin
                    iord       = 1'b1;
                    memwrite   = 1'b1;
                    instr_done = mem_ready;
                end
                S_RTEXEC: begin
                    alusrca    = 1'b1;
                    alucontrol = w_rt_alu;
                    illegal    = !w_funct_ok;
                    instr_done = !w_funct_ok;
                end
                S_ALUWB: begin
                    regdst     = 1'b1;
                    regwrite   = 1'b1;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    alusrca     = 1'b1;
                    alucontrol  = 3'b110;
                    pcsrc       = 2'b01;
                    pcwritecond = 1'b1;
                    invertzero  = (op == OP_BNE);
                    instr_done  = 1'b1;
                end
                S_IMMEXEC: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                    if (op == OP_ORI) begin
                        alucontrol = 3'b001;
                        zeroext    = 1'b1;
                    end
                end
                S_IMMWB: begin
                    regwrite   = 1'b1;
                    instr_done = 1'b1;
                end
                S_JUMP: begin
                    pcsrc      = 2'b10;
                    pcwrite    = 1'b1;
                    instr_done = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign state = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
//
// Instructions are planned at the instruction level: each one expands into its
// phase sequence (fetch with optional waits, decode, then the class-specific
// phases), every phase carrying the full expected output word and the inputs
// to drive. The scoreboard then replays the queue cycle by cycle.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

    localparam logic [5:0] RTYPE = 6'b000000;
    localparam logic [5:0] J     = 6'b000010;
    localparam logic [5:0] BEQ   = 6'b000100;
    localparam logic [5:0] BNE   = 6'b000101;
    localparam logic [5:0] ADDI  = 6'b001000;
    localparam logic [5:0] ORI   = 6'b001101;
    localparam logic [5:0] LW    = 6'b100011;
    localparam logic [5:0] SW    = 6'b101011;
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam int W = 25;

    logic       clock;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       mem_ready;
    logic       pcwrite, pcwritecond, invertzero, iord, memread, memwrite;
    logic       irwrite, memtoreg, regdst, regwrite, alusrca, zeroext;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;
    logic       illegal, instr_done;

    logic [W-1:0] exp_q[$];
    logic [12:0]  in_q[$];
    logic [W-1:0] obs;

    int n_tests   = 0;
    int n_fail    = 0;
    int n_instr   = 0;
    int done_seen = 0;

    multicycle_control dut (
        .clock(clock), .reset(reset), .op(op), .funct(funct),
        .mem_ready(mem_ready),
        .pcwrite(pcwrite), .pcwritecond(pcwritecond), .invertzero(invertzero),
        .iord(iord), .memread(memread), .memwrite(memwrite),
        .irwrite(irwrite), .memtoreg(memtoreg), .regdst(regdst),
        .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
        .zeroext(zeroext), .pcsrc(pcsrc), .alucontrol(alucontrol),
        .state(state), .illegal(illegal), .instr_done(instr_done)
    );

    assign obs = {state, pcwrite, pcwritecond, invertzero, iord, memread,
                  memwrite, irwrite, memtoreg, regdst, regwrite, alusrca,
                  alusrcb, zeroext, pcsrc, alucontrol, illegal, instr_done};

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Starts and ends at a falling edge; leaves the FSM in FETCH, reset high.
    task automatic apply_reset();
        reset = 1'b0;
        mem_ready = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    // ---------------- reference model ----------------
    function automatic logic known_op(logic [5:0] o);
        return (o == RTYPE) || (o == J) || (o == BEQ) || (o == BNE) ||
               (o == ADDI) || (o == ORI) || (o == LW) || (o == SW);
    endfunction

    function automatic logic known_funct(logic [5:0] f);
        return (f == 6'b100000) || (f == 6'b100010) || (f == 6'b100100) ||
               (f == 6'b100101) || (f == 6'b101010);
    endfunction

    // Expected output word for one phase, straight from the per-state table.
    function automatic logic [W-1:0] exp_out(int st, logic [5:0] o,
                                             logic [5:0] f, logic mr);
        logic pw = 0, pwc = 0, inv = 0, ad = 0, mrd = 0, mwr = 0, irw = 0;
        logic m2r = 0, rd = 0, rw = 0, sa = 0, zx = 0, ill = 0, dn = 0;
        logic [1:0] sb = 2'b00, ps = 2'b00;
        logic [2:0] alu = 3'b010;
        case (st)
            0: begin mrd = 1; sb = 2'b01; irw = mr; pw = mr; end
            1: begin sb = 2'b11; ill = !known_op(o); dn = !known_op(o); end
            2: begin sa = 1; sb = 2'b10; end
            3: begin ad = 1; mrd = 1; end
            4: begin m2r = 1; rw = 1; dn = 1; end
            5: begin ad = 1; mwr = 1; dn = mr; end
            6: begin
                sa = 1;
                case (f)
                    6'b100010: alu = 3'b110;
                    6'b100100: alu = 3'b000;
                    6'b100101: alu = 3'b001;
                    6'b101010: alu = 3'b111;
                    default:   alu = 3'b010;
                endcase
                ill = !known_funct(f);
                dn  = !known_funct(f);
            end
            7: begin rd = 1; rw = 1; dn = 1; end
            8: begin sa = 1; alu = 3'b110; ps = 2'b01; pwc = 1;
                     inv = (o == BNE); dn = 1; end
            9: begin sa = 1; sb = 2'b10;
                     if (o == ORI) begin alu = 3'b001; zx = 1; end end
            10: begin rw = 1; dn = 1; end
            11: begin ps = 2'b10; pw = 1; dn = 1; end
            default: begin end
        endcase
        return {4'(st), pw, pwc, inv, ad, mrd, mwr, irw, m2r, rd, rw, sa,
                sb, zx, ps, alu, ill, dn};
    endfunction

    task automatic push_cyc(int st, logic [5:0] o, logic [5:0] f, logic mr);
        exp_q.push_back(exp_out(st, o, f, mr));
        in_q.push_back({mr, o, f});
    endtask

    // Expand one instruction into its phases; waits add mem_ready=0 cycles.
    task automatic plan_instr(logic [5:0] o, logic [5:0] f, int fstall,
                              int mstall);
        for (int i = 0; i < fstall; i++) push_cyc(0, o, f, 1'b0);
        push_cyc(0, o, f, 1'b1);
        push_cyc(1, o, f, 1'($urandom_range(0, 1)));
        if (o == LW) begin
            push_cyc(2, o, f, 1'($urandom_range(0, 1)));
            for (int i = 0; i < mstall; i++) push_cyc(3, o, f, 1'b0);
            push_cyc(3, o, f, 1'b1);
            push_cyc(4, o, f, 1'($urandom_range(0, 1)));
        end else if (o == SW) begin
            push_cyc(2, o, f, 1'($urandom_range(0, 1)));
            for (int i = 0; i < mstall; i++) push_cyc(5, o, f, 1'b0);
            push_cyc(5, o, f, 1'b1);
        end else if (o == RTYPE) begin
            push_cyc(6, o, f, 1'($urandom_range(0, 1)));
            if (known_funct(f)) push_cyc(7, o, f, 1'($urandom_range(0, 1)));
        end else if (o == BEQ || o == BNE) begin
            push_cyc(8, o, f, 1'($urandom_range(0, 1)));
        end else if (o == ADDI || o == ORI) begin
            push_cyc(9, o, f, 1'($urandom_range(0, 1)));
            push_cyc(10, o, f, 1'($urandom_range(0, 1)));
        end else if (o == J) begin
            push_cyc(11, o, f, 1'($urandom_range(0, 1)));
        end
        n_instr++;
    endtask

    // ---------------- scoreboard driver ----------------
    task automatic run_cycles(int n);
        logic [W-1:0] e;
        logic [12:0]  d;
        for (int i = 0; i < n; i++) begin
            e = exp_q.pop_front();
            d = in_q.pop_front();
            mem_ready = d[12];
            op        = d[11:6];
            funct     = d[5:0];
            #1;
            n_tests++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL cycle op=%b funct=%b: got %h expected %h",
                         d[11:6], d[5:0], obs, e);
            end
            n_tests++;
            if (((memread & memwrite) | (regwrite & memwrite)) !== 1'b0) begin
                n_fail++;
                $display("FAIL strobe_exclusive: got rd=%b wr=%b rw=%b expected no overlap",
                         memread, memwrite, regwrite);
            end
            if (instr_done === 1'b1) done_seen++;
            @(negedge clock);
        end
    endtask

    task automatic run_all();
        run_cycles(exp_q.size());
    endtask

    task automatic check_done_count(string name, int d0, int i0);
        n_tests++;
        if ((done_seen - d0) !== (n_instr - i0)) begin
            n_fail++;
            $display("FAIL %s_done_count: got %0d expected %0d", name,
                     done_seen - d0, n_instr - i0);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        mem_ready = 1'b1;
        op = LW;
        funct = 6'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            #1;
            n_tests++;
            if ({state, pcwrite, pcwritecond, irwrite, memread, memwrite,
                 regwrite, illegal, instr_done, iord, alusrca, alusrcb, pcsrc}
                !== {4'd0, 8'd0, 1'b0, 1'b0, 2'b01, 2'b00}) begin
                n_fail++;
                $display("FAIL reset_hold: got state=%0d strobes=%b srcb=%b expected 0/0/01",
                         state, {pcwrite, pcwritecond, irwrite, memread,
                                 memwrite, regwrite, illegal, instr_done},
                         alusrcb);
            end
        end
        reset = 1'b1;
        #1;
        n_tests++;
        if ({state, memread, irwrite, pcwrite} !== {4'd0, 3'b111}) begin
            n_fail++;
            $display("FAIL reset_release: got state=%0d rd/ir/pc=%b expected 0/111",
                     state, {memread, irwrite, pcwrite});
        end
        @(negedge clock);
    endtask

    task automatic test_sequence();
        int d0, i0;
        apply_reset();
        d0 = done_seen;
        i0 = n_instr;
        plan_instr(LW, 6'd0, 0, 0);
        plan_instr(SW, 6'd0, 0, 0);
        plan_instr(RTYPE, F_ADD, 0, 0);
        plan_instr(BEQ, 6'd0, 0, 0);
        plan_instr(J, 6'd0, 0, 0);
        n_tests++;
        if (exp_q.size() !== 5 + 4 + 4 + 3 + 3) begin
            n_fail++;
            $display("FAIL seq_latency_plan: got %0d expected 19", exp_q.size());
        end
        run_all();
        check_done_count("sequence", d0, i0);
    endtask

    task automatic test_fetch_stall();
        apply_reset();
        plan_instr(RTYPE, 6'b100010, 4, 0);
        plan_instr(LW, 6'd0, 2, 3);
        plan_instr(SW, 6'd0, 1, 2);
        run_all();
    endtask

    task automatic test_branch_imm();
        apply_reset();
        plan_instr(BNE, 6'd0, 0, 0);
        plan_instr(ORI, 6'd0, 0, 0);
        plan_instr(ADDI, 6'd0, 0, 0);
        plan_instr(BEQ, 6'd0, 0, 0);
        run_all();
    endtask

    task automatic test_illegal();
        int d0, i0;
        apply_reset();
        d0 = done_seen;
        i0 = n_instr;
        plan_instr(6'b111111, 6'd0, 0, 0);
        plan_instr(RTYPE, 6'b000000, 0, 0);
        plan_instr(RTYPE, 6'b101010, 0, 0);
        run_all();
        check_done_count("illegal", d0, i0);
    endtask

    task automatic test_random();
        int d0, i0;
        logic [5:0] ops[8] = '{LW, SW, RTYPE, BEQ, BNE, ADDI, ORI, J};
        logic [5:0] fns[5] = '{6'b100000, 6'b100010, 6'b100100,
                               6'b100101, 6'b101010};
        logic [5:0] o, f;
        apply_reset();
        d0 = done_seen;
        i0 = n_instr;
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                o = 6'($urandom);
                while (known_op(o)) o = 6'($urandom);
            end else begin
                o = ops[$urandom_range(0, 7)];
            end
            if ($urandom_range(0, 5) == 0) f = 6'($urandom);
            else f = fns[$urandom_range(0, 4)];
            plan_instr(o, f, $urandom_range(0, 3), $urandom_range(0, 3));
        end
        run_all();
        check_done_count("random", d0, i0);
    endtask

    // Reset lands while the FSM waits in MEMRD (lw) or MEMWR (sw).
    task automatic test_reset_mid_access(logic is_sw);
        logic [5:0] o;
        o = is_sw ? SW : LW;
        apply_reset();
        plan_instr(o, 6'd0, 0, 5);
        run_cycles(5);
        exp_q.delete();
        in_q.delete();
        reset = 1'b0;
        mem_ready = 1'b1;
        #1;
        n_tests++;
        if ({memread, memwrite, regwrite} !== 3'b000) begin
            n_fail++;
            $display("FAIL midreset_strobes: got rd/wr/rw=%b expected 000",
                     {memread, memwrite, regwrite});
        end
        @(negedge clock);
        #1;
        n_tests++;
        if (state !== 4'd0) begin
            n_fail++;
            $display("FAIL midreset_state: got %0d expected 0", state);
        end
        reset = 1'b1;
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_tests++;
            if ({state, memread, memwrite, regwrite} !== {4'd0, 3'b100}) begin
                n_fail++;
                $display("FAIL midreset_after: got state=%0d rd/wr/rw=%b expected 0/100",
                         state, {memread, memwrite, regwrite});
            end
            @(negedge clock);
        end
    endtask

    // ---------------- main / report ----------------
    initial begin
        reset = 1'b0;
        mem_ready = 1'b0;
        op = 6'd0;
        funct = 6'd0;
        test_reset();
        test_sequence();
        test_fetch_stall();
        test_branch_imm();
        test_illegal();
        test_random();
        test_reset_mid_access(1'b0);
        test_reset_mid_access(1'b1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
